// File: rtl/aes_v2_round_seq.sv
// aes_v2_round_seq
//   Sequences one full AES round on a 128-bit state by driving a shared
//   32-bit word unit: four SubBytes word ops, four MixColumns word ops
//   (skipped on the final round), then a single-cycle AddRoundKey.
//
// Ports:
//   g_clk, g_reset   clock, synchronous active-high reset
//   start            single-cycle request, sampled only while idle
//   enc, last        round direction and final-round flag, captured on start
//   din, rk          input state and round key, captured on start
//   busy             high from the cycle after an accepted start until done
//   done             one-cycle pulse, dout valid
//   dout             result state, held until the next done
//   u_valid, u_sub   op request to the word unit and op select (1 = sub)
//   u_rs1, u_rs2     registered operands, stable while u_valid is high
//   u_enc, u_rot     captured enc, constant 0
//   u_ready, u_rd    unit completion pulse and result word
module aes_v2_round_seq #(
    parameter int unsigned NWORDS = 4
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         start,
    input  logic         enc,
    input  logic         last,
    input  logic [127:0] din,
    input  logic [127:0] rk,
    output logic         busy,
    output logic         done,
    output logic [127:0] dout,
    output logic         u_valid,
    output logic         u_sub,
    output logic [31:0]  u_rs1,
    output logic [31:0]  u_rs2,
    output logic         u_enc,
    output logic         u_rot,
    input  logic         u_ready,
    input  logic [31:0]  u_rd
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        SGAP = 3'd2,
        MIX  = 3'd3,
        MGAP = 3'd4,
        KEY  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] s [NWORDS];
    logic [31:0] t [NWORDS];
    logic [31:0] k [NWORDS];
    logic [1:0]  idx;
    logic [1:0]  idx_inc;
    logic        enc_q;
    logic        last_q;
    logic        hs;

    assign idx_inc = idx + 2'd1;
    assign hs      = u_valid && u_ready;
    assign u_enc   = enc_q;
    assign u_rot   = 1'b0;

    // Second SubBytes operand: right neighbour when encrypting, left when decrypting.
    function automatic logic [31:0] sub_rs2(input logic [1:0] j);
        logic [1:0] jn;
        jn = enc_q ? (j + 2'd1) : (j + 2'd3);
        return s[jn];
    endfunction

    // State register
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SUB;
            SUB:  if (hs) state_nxt = SGAP;
            SGAP: begin
                if (idx == 2'd3) state_nxt = last_q ? KEY : MIX;
                else             state_nxt = SUB;
            end
            MIX:  if (hs) state_nxt = MGAP;
            MGAP: begin
                if (idx == 2'd3) state_nxt = KEY;
                else             state_nxt = MIX;
            end
            KEY:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SUB, SGAP, MIX, MGAP, KEY: busy = 1'b1;
            DONE:                      done = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered unit interface
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                s[i] <= '0;
                t[i] <= '0;
                k[i] <= '0;
            end
            idx     <= '0;
            enc_q   <= 1'b0;
            last_q  <= 1'b0;
            u_valid <= 1'b0;
            u_sub   <= 1'b0;
            u_rs1   <= '0;
            u_rs2   <= '0;
            dout    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < NWORDS; i++) begin
                            s[i] <= din[32*i +: 32];
                            k[i] <= rk[32*i +: 32];
                        end
                        enc_q  <= enc;
                        last_q <= last;
                        idx    <= '0;
                    end
                end
                SUB: begin
                    // The first op of a round spends one cycle registering its
                    // operands; later ops are loaded ahead in the gap cycle.
                    if (!u_valid) begin
                        u_rs1   <= s[idx];
                        u_rs2   <= sub_rs2(idx);
                        u_sub   <= 1'b1;
                        u_valid <= 1'b1;
                    end else if (u_ready) begin
                        t[idx]  <= u_rd;
                        u_valid <= 1'b0;
                    end
                end
                SGAP: begin
                    if (idx == 2'd3) begin
                        idx <= '0;
                        if (!last_q) begin
                            u_rs1   <= t[0];
                            u_rs2   <= t[1];
                            u_sub   <= 1'b0;
                            u_valid <= 1'b1;
                        end
                    end else begin
                        idx     <= idx_inc;
                        u_rs1   <= s[idx_inc];
                        u_rs2   <= sub_rs2(idx_inc);
                        u_valid <= 1'b1;
                    end
                end
                MIX: begin
                    if (hs) begin
                        t[idx]  <= u_rd;
                        u_valid <= 1'b0;
                    end
                end
                MGAP: begin
                    // Operands come from t as it stands, so later ops see
                    // words already overwritten by earlier MIX results.
                    if (idx != 2'd3) begin
                        idx     <= idx_inc;
                        u_rs1   <= t[idx_inc];
                        u_rs2   <= t[idx_inc + 2'd1];
                        u_valid <= 1'b1;
                    end
                end
                KEY: begin
                    for (int unsigned i = 0; i < NWORDS; i++) begin
                        dout[32*i +: 32] <= t[i] ^ k[i];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_v2_round_seq.md
Name: aes_v2_round_seq

Overview:
- Sequencer that computes one full AES round on a 128-bit state.
- Drives a single shared 32-bit aes_v2_latency unit through a fixed micro-op schedule: four SubBytes word ops, then four MixColumns word ops (skipped on the final round), then AddRoundKey.
- Sits between the round-level core controller and the word-level datapath; only this block issues ops to that unit.

Parameters:
- NWORDS, 4, words per state; fixed, not intended to be overridden.

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- enc  in  1  1 = encrypt round, 0 = decrypt round; captured on start
- last  in  1  final round, skips MIX phase; captured on start
- din  in  128  input state; word i = din[32*i+31:32*i]; captured on start
- rk  in  128  round key; captured on start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, dout valid
- dout  out  128  result state; holds until the next done
- u_valid  out  1  op request to the unit
- u_sub  out  1  1 = sub op, 0 = mix op
- u_rs1  out  32  operand 1
- u_rs2  out  32  operand 2
- u_enc  out  1  = captured enc
- u_rot  out  1  always 0
- u_ready  in  1  unit completion; u_rd valid when u_valid && u_ready
- u_rd  in  32  unit result

Behaviour:
- Reset: state IDLE; busy=0, done=0, u_valid=0, u_sub=0, u_rs1=0, u_rs2=0, u_enc=0, dout=0, idx=0, all internal registers 0. Reset mid-operation abandons the round with no done pulse. The unit sees u_valid=0 the cycle after reset.
- States: IDLE, SUB, SGAP, MIX, MGAP, KEY, DONE.
- IDLE:
  - start=1 captures din into s[0..3], rk into k[0..3], enc, last; idx=0; goes to SUB.
  - start while not IDLE is ignored; no queueing.
- SUB (u_valid=1, u_sub=1):
  - u_rs1 = s[idx].
  - u_rs2 = s[(idx+1)&3] if enc, else s[(idx+3)&3].
  - On u_ready: t[idx] <= u_rd, then go to SGAP.
- SGAP (u_valid=0, exactly one cycle):
  - If idx==3: idx=0, go to MIX if !last, else KEY.
  - Otherwise idx++ and return to SUB.
- MIX (u_valid=1, u_sub=0):
  - u_rs1 = t[idx], u_rs2 = t[(idx+1)&3].
  - On u_ready: t[idx] <= u_rd, then go to MGAP.
- MGAP (u_valid=0, exactly one cycle):
  - If idx==3 go to KEY; otherwise idx++ and return to MIX.
  - MIX reads t words already overwritten; this order is intentional and is part of the contract.
- KEY (one cycle): dout[i] <= t[i] ^ k[i] for all i; go to DONE.
- DONE: done=1 for one cycle; go to IDLE; busy=0 from this cycle.
- Operands and u_sub are registered, stable the whole time u_valid is high, and change only in gap cycles.
- u_ready while u_valid=0 is ignored.
- u_ready in the first u_valid cycle is legal (zero-wait unit).
- Latency: with L = u_valid-high cycles per op, start to done = 1 + 4(L+1)·(last ? 1 : 2) + 2 cycles.
- The unit's ready is a one-cycle pulse. The sequencer never holds u_valid after the handshake cycle.
- idx is 2 bits and wraps only by explicit reset to 0 at phase end.

Test Plan:
- Stub unit: sub returns rs1+1, mix returns rs1^rs2, ready on 2nd valid cycle (L=2).
  - Stimulus: din=0, rk=0, last=1, enc=1, start.
  - Required: 4 sub ops with rs1=0; done 15 cycles after start; dout=128'h00000001_00000001_00000001_00000001; busy high cycles 2..15.
- Same stub, last=0, din=0, rk=0.
  - t after SUB = {1,1,1,1}.
  - MIX sequence: t0=1^1=0, t1=1^1=0, t2=1^1=0, t3=1^t0=1.
  - Required: dout words {0,0,0,1}; done 27 cycles after start.
- Operand routing, din words {A,B,C,D}={11111111,22222222,33333333,44444444}:
  - enc=1: SUB rs2 sequence must be B,C,D,A.
  - enc=0: SUB rs2 sequence must be D,A,B,C.
  - In both cases u_enc must match enc on every op.
- Key add: last=1, rk=all-FFs, stub as in the first scenario → dout words all FFFFFFFE.
- Protocol:
  - start pulses during busy are ignored; the first result is unchanged.
  - u_ready asserted during gap cycles has no effect.
  - Zero-wait unit (L=1), last=1 → done 11 cycles after start.
- Reset mid-MIX: assert g_reset one cycle, then:
  - Required: next cycle u_valid=0, busy=0, dout=0, no done pulse.
  - A following start completes normally.
